// File: rtl/riscv_fetch_pkg.sv
// Shared fetch-path definitions.
//   XLEN / ILEN      : address and instruction widths.
//   PC_STEP_DEFAULT  : byte increment between sequential fetches.
//   fetch_entry_t    : one prefetched instruction together with its PC.
package riscv_fetch_pkg;

  localparam int XLEN            = 64;
  localparam int ILEN            = 32;
  localparam int PC_STEP_DEFAULT = 4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Fetch-side bus: instruction-memory read port, redirect request and the
// decode handshake.
//   master : the fetch unit (drives Inst_Address, inst_valid/pc/data).
//   slave  : the environment (memory, redirect source, decode).
//
// Decode handshake: an entry transfers on a rising clk edge where
// inst_valid and inst_ready are both high. inst_valid never depends on
// inst_ready, and while inst_valid is high and inst_ready low the
// inst_pc/inst_data payload is held stable.
interface instruction_fetch_unit_if;
  import riscv_fetch_pkg::*;

  logic [XLEN-1:0] Inst_Address;
  logic [ILEN-1:0] Instruction;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            inst_valid;
  logic            inst_ready;
  logic [XLEN-1:0] inst_pc;
  logic [ILEN-1:0] inst_data;

  modport master (
    output Inst_Address,
    input  Instruction,
    input  redirect_valid,
    input  redirect_pc,
    output inst_valid,
    input  inst_ready,
    output inst_pc,
    output inst_data
  );

  modport slave (
    input  Inst_Address,
    output Instruction,
    output redirect_valid,
    output redirect_pc,
    input  inst_valid,
    output inst_ready,
    input  inst_pc,
    input  inst_data
  );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO of fetch_entry_t.
//   clk, reset : clock, asynchronous active-high reset
//   push/wr_entry : write an entry (caller guarantees ~full or pop)
//   pop        : drop the head entry (caller guarantees ~empty)
//   flush      : empty the FIFO; overrides push and pop
//   rd_entry   : head entry (raw storage contents, qualify with empty)
//   full, empty, count : occupancy
module fetch_fifo
  import riscv_fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic               pop,
  input  logic               flush,
  input  fetch_entry_t       wr_entry,
  output fetch_entry_t       rd_entry,
  output logic               full,
  output logic               empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

  fetch_entry_t      mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;

  // Storage has no reset; readers gate it with empty.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr] <= wr_entry;
    end
  end

  // Pointers are AW bits wide, so they wrap modulo DEPTH for free.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign rd_entry = mem[rd_ptr];
  assign full     = (count == DEPTH_CNT);
  assign empty    = (count == '0);

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the fetch PC, reads the zero-latency
// instruction memory, buffers {pc, instruction} in a prefetch FIFO and
// presents the head to decode. A redirect flushes the FIFO and restarts
// fetch at the (word-aligned) redirect target.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : instruction_fetch_unit_if.master (memory, redirect, decode)
module instruction_fetch_unit
  import riscv_fetch_pkg::*;
#(
  parameter int              FIFO_DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC   = 64'h0,
  parameter int              PC_STEP    = PC_STEP_DEFAULT
) (
  input  logic                      clk,
  input  logic                      reset,
  instruction_fetch_unit_if.master  bus
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [XLEN-1:0] fetch_pc;
  logic            push;
  logic            pop;
  logic            full;
  logic            empty;
  logic [CW-1:0]   count;
  fetch_entry_t    wr_entry;
  fetch_entry_t    head;

  // Redirect masks valid, so no handshake can complete on a redirect edge.
  assign bus.inst_valid = (count != '0) && !bus.redirect_valid;
  assign pop            = bus.inst_valid && bus.inst_ready;
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign push           = !bus.redirect_valid && (!full || pop);

  assign wr_entry.pc    = fetch_pc;
  assign wr_entry.inst  = bus.Instruction;

  assign bus.Inst_Address = fetch_pc;
  assign bus.inst_pc      = empty ? '0 : head.pc;
  assign bus.inst_data    = empty ? '0 : head.inst;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
    end else if (bus.redirect_valid) begin
      fetch_pc <= {bus.redirect_pc[XLEN-1:2], 2'b00};
    end else if (push) begin
      fetch_pc <= fetch_pc + XLEN'(PC_STEP);
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .pop      (pop),
    .flush    (bus.redirect_valid),
    .wr_entry (wr_entry),
    .rd_entry (head),
    .full     (full),
    .empty    (empty),
    .count    (count)
  );

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed scenarios followed by random
// ready/redirect traffic, all checked against a queue-based model.
module tb_instruction_fetch_unit;
  import riscv_fetch_pkg::*;

  localparam int DEPTH = 4;

  logic clk;
  logic reset;
  int   tests;
  int   fails;

  // Model: PCs of buffered entries in order, plus the next fetch address.
  logic [63:0] exp_q [$];
  logic [63:0] m_pc;

  instruction_fetch_unit_if bus ();

  instruction_fetch_unit #(
    .FIFO_DEPTH (DEPTH),
    .RESET_PC   (64'h0),
    .PC_STEP    (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- instruction memory ----------------
  function automatic logic [31:0] mem_word(input logic [63:0] a);
    if (a == 64'h0) return 32'h02853483;
    return (a[31:0] * 32'h9E3779B1) ^ a[63:32] ^ 32'h0000_0013;
  endfunction

  assign bus.Instruction = mem_word(bus.Inst_Address);

  // ---------------- checkers ----------------
  task automatic check64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // ---------------- driver + model step ----------------
  // Called with clk low. Drives inputs, checks outputs before the edge,
  // then applies the fetch rules to the model across the edge.
  task automatic step(input logic rdy, input logic rv, input logic [63:0] rpc);
    logic exp_valid;
    logic do_pop;
    int   size_before;
    bus.inst_ready     = rdy;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    #1;
    exp_valid = (exp_q.size() != 0) && !rv;
    check1 ("inst_valid",   bus.inst_valid, exp_valid);
    check64("Inst_Address", bus.Inst_Address, m_pc);
    if (exp_q.size() != 0) begin
      check64("inst_pc",   bus.inst_pc, exp_q[0]);
      check32("inst_data", bus.inst_data, mem_word(exp_q[0]));
    end else begin
      check64("inst_pc_empty",   bus.inst_pc, 64'h0);
      check32("inst_data_empty", bus.inst_data, 32'h0);
    end
    @(posedge clk);
    if (rv) begin
      exp_q.delete();
      m_pc = {rpc[63:2], 2'b00};
    end else begin
      size_before = exp_q.size();
      do_pop = exp_valid && rdy;
      if (do_pop) void'(exp_q.pop_front());
      if (size_before < DEPTH || do_pop) begin
        exp_q.push_back(m_pc);
        m_pc = m_pc + 64'd4;
      end
    end
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b1;
    bus.inst_ready     = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 64'h0;
    exp_q.delete();
    m_pc = 64'h0;

    // Reset state
    @(negedge clk);
    check64("rst_addr",  bus.Inst_Address, 64'h0);
    check1 ("rst_valid", bus.inst_valid, 1'b0);
    check64("rst_pc",    bus.inst_pc, 64'h0);
    check32("rst_data",  bus.inst_data, 32'h0);
    reset = 1'b0;

    // First fetch after reset release
    step(1'b1, 1'b0, 64'h0);
    check1 ("first_valid", bus.inst_valid, 1'b1);
    check64("first_pc",    bus.inst_pc, 64'h0);
    check32("first_data",  bus.inst_data, 32'h02853483);

    // Streaming with ready held high
    repeat (3) step(1'b1, 1'b0, 64'h0);
    check64("stream_addr", bus.Inst_Address, 64'h10);

    // Stall until full; address must stop advancing
    repeat (4) step(1'b0, 1'b0, 64'h0);
    check64("full_addr", bus.Inst_Address, 64'h1C);
    check64("full_head", bus.inst_pc, 64'hC);
    // Pop and push on the same edge while full
    step(1'b1, 1'b0, 64'h0);
    check64("full_pp_addr", bus.Inst_Address, 64'h20);
    check64("full_pp_head", bus.inst_pc, 64'h10);
    step(1'b0, 1'b0, 64'h0);
    check64("full_hold_addr", bus.Inst_Address, 64'h20);

    // Redirect from a full FIFO
    step(1'b1, 1'b1, 64'h8);
    check64("redir_addr",  bus.Inst_Address, 64'h8);
    check1 ("redir_empty", bus.inst_valid, 1'b0);
    step(1'b0, 1'b0, 64'h0);
    check1 ("redir_valid", bus.inst_valid, 1'b1);
    check64("redir_pc",    bus.inst_pc, 64'h8);

    // Low address bits ignored
    step(1'b1, 1'b1, 64'h6);
    check64("redir_align", bus.Inst_Address, 64'h4);

    // PC wraps modulo 2^64
    step(1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
    step(1'b1, 1'b0, 64'h0);
    check64("wrap_addr", bus.Inst_Address, 64'h0);
    check64("wrap_head", bus.inst_pc, 64'hFFFF_FFFF_FFFF_FFFC);

    // Asynchronous reset with entries buffered
    step(1'b1, 1'b1, 64'h100);
    repeat (3) step(1'b0, 1'b0, 64'h0);
    check1("pre_rst_valid", bus.inst_valid, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    check1 ("async_valid", bus.inst_valid, 1'b0);
    check64("async_addr",  bus.Inst_Address, 64'h0);
    check64("async_pc",    bus.inst_pc, 64'h0);
    exp_q.delete();
    m_pc = 64'h0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    step(1'b1, 1'b0, 64'h0);
    check64("restart_pc",   bus.inst_pc, 64'h0);
    check32("restart_data", bus.inst_data, 32'h02853483);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      logic        r;
      logic        rv;
      logic [63:0] rpc;
      r   = ($urandom_range(0, 3) != 0);
      rv  = ($urandom_range(0, 9) == 0);
      rpc = {$urandom(), $urandom()};
      step(r, rv, rpc);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global time bound
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
